ex_muldiv_iter: RTL and testbench
=================================

# ex_muldiv_iter

Iterative multiply/divide unit for the execute stage, covering LoongArch mul.w/mulh.w/mulh.wu/div.w/mod.w/div.wu/mod.wu. It accepts one operation when the execute stage raises its multiply/divide request, computes one bit per cycle, and holds the result until the pipeline takes it. It asserts `busy` so hazard control can stall the front end. Width and tag width are parametrised; the unit carries a writeback tag and supports pipeline flush.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥4)
- `TAG_W`, 5, width of the destination tag passed through unchanged
- `clk` input 1: clock; all state changes on the rising edge
- `rst` input 1: reset, synchronous and active-high
- `in_valid` input 1: operation request from the execute stage
- `in_ready` output 1: unit can accept; `= (state==IDLE) & ~flush & ~rst`
- `op` input 3: 000 MUL, 001 MULH, 010 MULHU, 011 reserved, 100 DIV, 101 MOD, 110 DIVU, 111 MODU
- `src_a` input WIDTH: multiplicand / dividend
- `src_b` input WIDTH: multiplier / divisor
- `tag` input TAG_W: destination register tag
- `flush` input 1: abort the in-flight operation (branch mispredict)
- `out_valid` output 1: result available
- `out_ready` input 1: consumer accepts the result
- `result` output WIDTH: result word
- `out_tag` output TAG_W: tag of the operation held in `result`
- `busy` output 1: `state != IDLE`; drives the pipeline stall

## Operation
- States: IDLE, CALC, DONE.
- IDLE→CALC on `in_valid & in_ready`. Latch op and tag, and store |a| and |b|. Magnitudes apply for the signed ops MULH, DIV and MOD; the raw value applies otherwise.
- IDLE→DONE directly, as a fast path, for either of:
  - divide ops with `src_b==0`: quotient = all ones, remainder = `src_a` unmodified;
  - op 011: result 0.
- CALC, multiply: shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle, WIDTH cycles.
  - MUL returns the low word.
  - MULHU returns the high word.
  - MULH negates the 2·WIDTH product when the operand signs differ, then returns the high word.
- CALC, divide: restoring division, one quotient bit per cycle, WIDTH cycles.
  - Signed ops negate the quotient when the signs differ.
  - The remainder takes the sign of the dividend.
  - `0x80000000 / -1` (WIDTH=32) yields quotient `0x80000000` and remainder 0 with no special case.
- CALC→DONE when the iteration counter reaches WIDTH-1. `result` and `out_tag` are registered on this edge with the sign fix applied.
- DONE: `out_valid=1`. `result` and `out_tag` stay stable while `out_ready=0`. DONE→IDLE on `out_valid & out_ready`.
- `flush` (any state) → IDLE on the next edge and `out_valid` drops. The aborted result is never presented. `flush` has priority over `out_ready`, over a new accept, and over counter completion.
- Only one operation is in flight. No accept occurs in CALC or DONE.

## Timing
- Reset values: state IDLE, `out_valid=0`, `result=0`, `out_tag=0`, `busy=0`, counter 0. `in_ready` reads 0 while `rst` is high and 1 in the first cycle after.
- Accept edge at the end of cycle N:
  - normal ops: `out_valid` is first high in cycle N+WIDTH+1, and `busy` is high from N+1 through the transfer cycle;
  - fast path: `out_valid` is high in cycle N+1.
- When the transfer occurs at the end of cycle M, `in_ready` is 1 in cycle M+1. The minimum issue interval is WIDTH+2 cycles.
- `rst` or `flush` mid-CALC: the counter clears and the next accept starts from a clean state. No partial state may leak into the next result.
- `out_ready` is ignored outside DONE.

## Test plan
- MUL 7 × `0xFFFFFFFD`, tag 9 → `result=0xFFFFFFEB`, `out_tag=9`, `out_valid` first high at N+33 (WIDTH=32).
- MULH `0x80000000`×`0x80000000` → `0x40000000`. MULHU `0xFFFFFFFF`×`0xFFFFFFFF` → `0xFFFFFFFE`. MULH `0xFFFFFFFF`×1 → `0xFFFFFFFF`.
- DIV `0xFFFFFFF9`/2 → `0xFFFFFFFD`. MOD → `0xFFFFFFFF`. DIVU → `0x7FFFFFFC`. MODU → 1. DIV `0x80000000`/`0xFFFFFFFF` → `0x80000000`, MOD → 0.
- DIV 5/0 → `0xFFFFFFFF` at N+1. MODU 5/0 → 5 at N+1. Op 011 → 0 at N+1.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE → `result`/`out_tag` stable, `in_ready=0`, `busy=1`. Then raise `out_ready` → single transfer, and `in_ready=1` next cycle.
- Flush at N+10 during DIV → no `out_valid`, IDLE next cycle. An immediate MUL 3×4 → 12 at the correct latency. Repeat with `rst` pulsed at N+10 → reset values hold.

Source files
------------

// File: rtl/ex_muldiv_iter.sv
// Iterative multiply/divide unit for the execute stage.
// Produces one product or quotient bit per cycle and holds the result until it is taken.
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  operation handshake; op selects MUL/MULH/MULHU/DIV/MOD/DIVU/MODU
//   src_a, src_b, tag  operands and destination tag, captured on accept
//   flush              abort the in-flight operation; the result is never presented
//   out_valid/out_ready result handshake; result and out_tag stay stable while stalled
//   busy               high whenever the unit is not idle (front-end stall)
module ex_muldiv_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [TAG_W-1:0] tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    localparam logic [2:0] OpMul   = 3'b000;
    localparam logic [2:0] OpMulh  = 3'b001;
    localparam logic [2:0] OpMulhu = 3'b010;
    localparam logic [2:0] OpRsvd  = 3'b011;
    localparam logic [2:0] OpDiv   = 3'b100;
    localparam logic [2:0] OpMod   = 3'b101;
    localparam logic [2:0] OpDivu  = 3'b110;
    localparam logic [2:0] OpModu  = 3'b111;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]   mag_q, mag_d;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, hi_d;     // product high word / partial remainder
    logic [WIDTH-1:0]   lo_q, lo_d;     // multiplier / dividend, shifting into product low / quotient
    logic               neg_q, neg_d;   // operand signs differ (signed ops only)
    logic               rneg_q, rneg_d; // dividend negative (signed ops only)
    logic [WIDTH-1:0]   result_q, result_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;

    logic               in_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   mulh_neg_hi;
    logic [WIDTH-1:0]   final_res;

    assign in_ready  = (state_q == StIdle) & ~flush & ~rst;
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign out_tag   = out_tag_q;

    assign in_signed = (op == OpMulh) || (op == OpDiv) || (op == OpMod);
    assign a_mag     = (in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag     = (in_signed && src_b[WIDTH-1]) ? -src_b : src_b;

    // One iteration step for both algorithms.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        // Remainder < divisor, so bit WIDTH of the difference is the borrow.
        div_diff  = div_shift - {1'b0, mag_q};
        if (op_q[2]) begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // High word of the negated double-width product: ~hi plus the carry out of ~lo + 1.
    assign mulh_neg_hi = ~step_hi + {{(WIDTH-1){1'b0}}, (step_lo == '0)};

    always_comb begin
        case (op_q)
            OpMul:   final_res = step_lo;
            OpMulh:  final_res = neg_q ? mulh_neg_hi : step_hi;
            OpMulhu: final_res = step_hi;
            OpDiv:   final_res = neg_q ? -step_lo : step_lo;
            OpMod:   final_res = rneg_q ? -step_hi : step_hi;
            OpDivu:  final_res = step_lo;
            OpModu:  final_res = step_hi;
            default: final_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        tag_d     = tag_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_d     = neg_q;
        rneg_d    = rneg_q;
        result_d  = result_q;
        out_tag_d = out_tag_q;

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        op_d   = op;
                        tag_d  = tag;
                        cnt_d  = '0;
                        hi_d   = '0;
                        neg_d  = in_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rneg_d = in_signed & src_a[WIDTH-1];
                        if (op == OpRsvd) begin
                            result_d  = '0;
                            out_tag_d = tag;
                            state_d   = StDone;
                        end else if (op[2] && (src_b == '0)) begin
                            // Divide by zero: quotient all ones, remainder is the raw dividend.
                            result_d  = op[0] ? src_a : '1;
                            out_tag_d = tag;
                            state_d   = StDone;
                        end else begin
                            mag_d   = op[2] ? b_mag : a_mag;
                            lo_d    = op[2] ? a_mag : b_mag;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        cnt_d     = '0;
                        result_d  = final_res;
                        out_tag_d = tag_q;
                        state_d   = StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            op_q      <= '0;
            tag_q     <= '0;
            cnt_q     <= '0;
            mag_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            result_q  <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            mag_q     <= mag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_q     <= neg_d;
            rneg_q    <= rneg_d;
            result_q  <= result_d;
            out_tag_q <= out_tag_d;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed bench for ex_muldiv_iter: table of operations with hand-computed results and
// latencies, plus backpressure, flush and mid-operation reset sequences.
module tb_ex_muldiv_iter;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned TAG_W   = 5;
    localparam int          LatCalc = WIDTH + 1;
    localparam int          LatFast = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [TAG_W-1:0] tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    ex_muldiv_iter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .tag       (tag),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp;
        int               lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                                input logic [WIDTH-1:0] e, input int l);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.tag = t; v.exp = e; v.lat = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op, measure cycles from accept edge to first out_valid, check and drain.
    task automatic run_op(input string name, input logic [2:0] o, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t,
                          input logic [WIDTH-1:0] e, input int l);
        int lat;
        bit seen;
        @(negedge clk);
        check({name, " in_ready"}, in_ready, 1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = o;
        src_a     = a;
        src_b     = b;
        tag       = t;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = out_valid;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no out_valid within %0d cycles", name, lat);
        end else begin
            check({name, " latency"}, 64'(lat), 64'(l));
            check({name, " result"}, result, e);
            check({name, " out_tag"}, out_tag, t);
            check({name, " busy"}, busy, 1);
            @(posedge clk);
            @(negedge clk);
            check({name, " post out_valid"}, out_valid, 0);
            check({name, " post in_ready"}, in_ready, 1);
        end
    endtask

    // Start a DIV, abort it at cycle N+10 by flush or reset, then issue MUL 3x4.
    task automatic abort_test(input bit use_rst);
        string nm;
        nm = use_rst ? "rst" : "flush";
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'b100;
        src_a     = 32'd100;
        src_b     = 32'd7;
        tag       = 5'd4;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check({nm, " mid busy"}, busy, 1);
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        check({nm, " out_valid"}, out_valid, 0);
        check({nm, " busy"}, busy, 0);
        check({nm, " in_ready"}, in_ready, 1);
        if (use_rst) begin
            check("rst result", result, 0);
            check("rst out_tag", out_tag, 0);
        end
        run_op({nm, " mul after"}, 3'b000, 32'd3, 32'd4, 5'd6, 32'd12, LatCalc);
    endtask

    initial begin
        int wait_cyc;
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        op        = '0;
        src_a     = '0;
        src_b     = '0;
        tag       = '0;

        vecs.push_back(mk(3'b000, 32'd7,        32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, LatCalc));
        vecs.push_back(mk(3'b001, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000, LatCalc));
        vecs.push_back(mk(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, LatCalc));
        vecs.push_back(mk(3'b001, 32'hFFFFFFFF, 32'd1,        5'd3,  32'hFFFFFFFF, LatCalc));
        vecs.push_back(mk(3'b010, 32'h80000000, 32'd2,        5'd4,  32'd1,        LatCalc));
        vecs.push_back(mk(3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, LatCalc));
        vecs.push_back(mk(3'b101, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, LatCalc));
        vecs.push_back(mk(3'b110, 32'hFFFFFFF9, 32'd2,        5'd7,  32'h7FFFFFFC, LatCalc));
        vecs.push_back(mk(3'b111, 32'hFFFFFFF9, 32'd2,        5'd8,  32'd1,        LatCalc));
        vecs.push_back(mk(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, LatCalc));
        vecs.push_back(mk(3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'd0,        LatCalc));
        vecs.push_back(mk(3'b100, 32'd7,        32'hFFFFFFFE, 5'd12, 32'hFFFFFFFD, LatCalc));
        vecs.push_back(mk(3'b101, 32'd7,        32'hFFFFFFFE, 5'd13, 32'd1,        LatCalc));
        vecs.push_back(mk(3'b110, 32'd100,      32'd7,        5'd14, 32'd14,       LatCalc));
        vecs.push_back(mk(3'b111, 32'd100,      32'd7,        5'd15, 32'd2,        LatCalc));
        vecs.push_back(mk(3'b100, 32'd5,        32'd0,        5'd16, 32'hFFFFFFFF, LatFast));
        vecs.push_back(mk(3'b111, 32'd5,        32'd0,        5'd17, 32'd5,        LatFast));
        vecs.push_back(mk(3'b101, 32'hFFFFFFF9, 32'd0,        5'd18, 32'hFFFFFFF9, LatFast));
        vecs.push_back(mk(3'b110, 32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, LatFast));
        vecs.push_back(mk(3'b011, 32'd123,      32'd456,      5'd20, 32'd0,        LatFast));

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset result", result, 0);
        check("reset out_tag", out_tag, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", in_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                   vecs[i].exp, vecs[i].lat);
        end

        // Backpressure: DIVU 100/7 held for five cycles in DONE.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b110;
        src_a     = 32'd100;
        src_b     = 32'd7;
        tag       = 5'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_cyc = 0;
        while (!out_valid && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("bp reached done", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d result", c), result, 32'd14);
            check($sformatf("bp%0d out_tag", c), out_tag, 5'd3);
            check($sformatf("bp%0d out_valid", c), out_valid, 1);
            check($sformatf("bp%0d in_ready", c), in_ready, 0);
            check($sformatf("bp%0d busy", c), busy, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp post out_valid", out_valid, 0);
        check("bp post in_ready", in_ready, 1);
        check("bp post busy", busy, 0);

        abort_test(1'b0);
        abort_test(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
